// File: rtl/video_timing_monitor.sv
// video_timing_monitor: passive checker for generator video timing.
// Measures line period, DE run length, active/total lines and a pixel
// checksum per frame, compares each finished frame against the expected
// timing, and reports error flags, a lock indication and a frame count.
module video_timing_monitor #(
  parameter logic SYNC_ACTIVE = 1'b1,
  parameter int   EXP_H_TOTAL = 1688,
  parameter int   EXP_WIDTH   = 1280,
  parameter int   EXP_HEIGHT  = 1024,
  parameter int   EXP_V_TOTAL = 1066,
  parameter int   LOCK_FRAMES = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        HS,
  input  logic        VS,
  input  logic        DE,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic [11:0] LineTotal,
  output logic [11:0] LineWidth,
  output logic [11:0] FrameActive,
  output logic [11:0] FrameTotal,
  output logic [15:0] FrameSum,
  output logic [3:0]  ErrFlags,
  output logic        FrameDone,
  output logic        Locked,
  output logic [15:0] FrameCount
);

  localparam logic [11:0] EXP_H    = 12'(EXP_H_TOTAL);
  localparam logic [11:0] EXP_W    = 12'(EXP_WIDTH);
  localparam logic [11:0] EXP_A    = 12'(EXP_HEIGHT);
  localparam logic [11:0] EXP_V    = 12'(EXP_V_TOTAL);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  // Input pipeline: stage1 samples pins, stage2 holds previous stage1.
  logic       hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic [7:0] r1_q, g1_q, b1_q;

  // Measurement state.
  logic [11:0] hcnt_q, hcnt_d, dcnt_q, dcnt_d, vcnt_q, vcnt_d, acnt_q, acnt_d;
  logic [15:0] psum_q, psum_d;
  logic        line_armed_q, line_armed_d, de_armed_q, de_armed_d;
  logic        frame_armed_q, frame_armed_d;
  logic [1:0]  sticky_q, sticky_d;
  logic [3:0]  good_q, good_d;

  // Registered outputs.
  logic [11:0] line_total_q, line_total_d, line_width_q, line_width_d;
  logic [11:0] frame_active_q, frame_active_d, frame_total_q, frame_total_d;
  logic [15:0] frame_sum_q, frame_sum_d, frame_count_q, frame_count_d;
  logic [3:0]  err_q, err_d;
  logic        done_q, done_d, locked_q, locked_d;

  // Edge detects and per-cycle helpers.
  logic       hs_lead, vs_lead, de_rise, de_fall, set0, set1;
  logic [9:0] pix;
  logic [3:0] err_now;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  assign hs_lead = (hs1_q == SYNC_ACTIVE) && (hs2_q != SYNC_ACTIVE);
  assign vs_lead = (vs1_q == SYNC_ACTIVE) && (vs2_q != SYNC_ACTIVE);
  assign de_rise = de1_q && !de2_q;
  assign de_fall = !de1_q && de2_q;
  assign pix     = {2'b00, r1_q} + {2'b00, g1_q} + {2'b00, b1_q};

  // Next-state: line/width measurement, frame accumulation, frame report and lock.
  always_comb begin
    // NOTE: every _d takes its current value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    hcnt_d         = sat_inc(hcnt_q);
    dcnt_d         = dcnt_q;
    vcnt_d         = vcnt_q;
    acnt_d         = acnt_q;
    psum_d         = psum_q;
    line_armed_d   = line_armed_q;
    de_armed_d     = de_armed_q;
    frame_armed_d  = frame_armed_q;
    good_d         = good_q;
    line_total_d   = line_total_q;
    line_width_d   = line_width_q;
    frame_active_d = frame_active_q;
    frame_total_d  = frame_total_q;
    frame_sum_d    = frame_sum_q;
    frame_count_d  = frame_count_q;
    err_d          = err_q;
    locked_d       = locked_q;
    done_d         = 1'b0;
    set0           = 1'b0;
    set1           = 1'b0;
    err_now        = 4'd0;

    // Line period: first HS edge after reset only arms.
    if (hs_lead) begin
      if (line_armed_q) begin
        line_total_d = hcnt_q;
        set0         = (hcnt_q != EXP_H);
      end
      hcnt_d       = 12'd1;
      line_armed_d = 1'b1;
    end

    // DE run length; a fall with no prior rise is ignored.
    if (de_rise) begin
      dcnt_d     = 12'd1;
      de_armed_d = 1'b1;
    end else if (de1_q) begin
      dcnt_d = sat_inc(dcnt_q);
    end
    if (de_fall && de_armed_q) begin
      line_width_d = dcnt_q;
      set1         = (dcnt_q != EXP_W);
    end
    sticky_d = sticky_q | {set1, set0};

    // Frame accumulators.
    if (hs_lead) vcnt_d = sat_inc(vcnt_q);
    if (de_rise) acnt_d = sat_inc(acnt_q);
    if (de1_q)   psum_d = psum_q + {6'd0, pix};

    // Frame boundary: report the finished frame, then restart counters with
    // whatever events coincide with this VS edge.
    if (vs_lead) begin
      if (frame_armed_q) begin
        err_now        = {vcnt_q != EXP_V, acnt_q != EXP_A,
                          sticky_q[1] | set1, sticky_q[0] | set0};
        frame_total_d  = vcnt_q;
        frame_active_d = acnt_q;
        frame_sum_d    = psum_q;
        err_d          = err_now;
        done_d         = 1'b1;
        frame_count_d  = frame_count_q + 16'd1;
        if (err_now == 4'd0) begin
          good_d   = (good_q == LOCK_N) ? good_q : good_q + 4'd1;
          locked_d = (good_d == LOCK_N);
        end else begin
          good_d   = 4'd0;
          locked_d = 1'b0;
        end
      end
      frame_armed_d = 1'b1;
      sticky_d      = 2'b00;
      vcnt_d        = hs_lead ? 12'd1 : 12'd0;
      acnt_d        = de_rise ? 12'd1 : 12'd0;
      psum_d        = de1_q ? {6'd0, pix} : 16'd0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (Reset) begin
      // NOTE: everything is reset here; this block holds no memory arrays.
      {hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q} <= '0;
      r1_q <= '0; g1_q <= '0; b1_q <= '0;
      hcnt_q <= '0; dcnt_q <= '0; vcnt_q <= '0; acnt_q <= '0; psum_q <= '0;
      line_armed_q <= 1'b0; de_armed_q <= 1'b0; frame_armed_q <= 1'b0;
      sticky_q <= '0; good_q <= '0;
      line_total_q <= '0; line_width_q <= '0; frame_active_q <= '0;
      frame_total_q <= '0; frame_sum_q <= '0; frame_count_q <= '0;
      err_q <= '0; done_q <= 1'b0; locked_q <= 1'b0;
    end else begin
      hs1_q <= HS; vs1_q <= VS; de1_q <= DE;
      r1_q  <= R;  g1_q  <= G;  b1_q  <= B;
      hs2_q <= hs1_q; vs2_q <= vs1_q; de2_q <= de1_q;
      hcnt_q <= hcnt_d; dcnt_q <= dcnt_d; vcnt_q <= vcnt_d; acnt_q <= acnt_d;
      psum_q <= psum_d;
      line_armed_q <= line_armed_d; de_armed_q <= de_armed_d;
      frame_armed_q <= frame_armed_d;
      sticky_q <= sticky_d; good_q <= good_d;
      line_total_q <= line_total_d; line_width_q <= line_width_d;
      frame_active_q <= frame_active_d; frame_total_q <= frame_total_d;
      frame_sum_q <= frame_sum_d; frame_count_q <= frame_count_d;
      err_q <= err_d; done_q <= done_d; locked_q <= locked_d;
    end
  end

  assign LineTotal   = line_total_q;
  assign LineWidth   = line_width_q;
  assign FrameActive = frame_active_q;
  assign FrameTotal  = frame_total_q;
  assign FrameSum    = frame_sum_q;
  assign ErrFlags    = err_q;
  assign FrameDone   = done_q;
  assign Locked      = locked_q;
  assign FrameCount  = frame_count_q;

endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor: directed bench for video_timing_monitor using a
// reduced timing (16 clocks/line, 8-pixel DE, 4 active of 8 lines).
module tb_video_timing_monitor;

  localparam logic SYNC = 1'b1;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        HS = 1'b0, VS = 1'b0, DE = 1'b0;
  logic [7:0]  R = 8'd0, G = 8'd0, B = 8'd0;
  logic [11:0] LineTotal, LineWidth, FrameActive, FrameTotal;
  logic [15:0] FrameSum, FrameCount;
  logic [3:0]  ErrFlags;
  logic        FrameDone, Locked;

  int n_checks = 0;
  int n_pass   = 0;
  int dbl_cnt  = 0;
  logic prev_done = 1'b0;

  // Per-FrameDone snapshots captured by the monitor.
  logic [3:0]  q_err[$];
  logic        q_lock[$];
  logic [15:0] q_cnt[$], q_sum[$];
  logic [11:0] q_tot[$], q_act[$], q_lt[$], q_lw[$];

  video_timing_monitor #(
    .SYNC_ACTIVE(SYNC), .EXP_H_TOTAL(16), .EXP_WIDTH(8),
    .EXP_HEIGHT(4), .EXP_V_TOTAL(8), .LOCK_FRAMES(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .HS(HS), .VS(VS), .DE(DE),
    .R(R), .G(G), .B(B),
    .LineTotal(LineTotal), .LineWidth(LineWidth),
    .FrameActive(FrameActive), .FrameTotal(FrameTotal),
    .FrameSum(FrameSum), .ErrFlags(ErrFlags), .FrameDone(FrameDone),
    .Locked(Locked), .FrameCount(FrameCount)
  );

  always #5 Clock = ~Clock;

  // Log outputs on every FrameDone and flag pulses longer than one cycle.
  always @(negedge Clock) begin
    if (FrameDone) begin
      q_err.push_back(ErrFlags); q_lock.push_back(Locked);
      q_cnt.push_back(FrameCount); q_sum.push_back(FrameSum);
      q_tot.push_back(FrameTotal); q_act.push_back(FrameActive);
      q_lt.push_back(LineTotal); q_lw.push_back(LineWidth);
    end
    if (FrameDone && prev_done) dbl_cnt++;
    prev_done = FrameDone;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_log();
    q_err.delete(); q_lock.delete(); q_cnt.delete(); q_sum.delete();
    q_tot.delete(); q_act.delete(); q_lt.delete(); q_lw.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      HS = !SYNC; VS = !SYNC; DE = 1'b0; R = 8'd0; G = 8'd0; B = 8'd0;
    end
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b1; HS = !SYNC; VS = !SYNC; DE = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    clear_log();
  endtask

  // One line: HS for 2 clocks, DE from clock 4 for de_w clocks.
  task automatic send_line(input int len, input int de_w, input bit vs_on,
                           input logic [7:0] pix);
    for (int c = 0; c < len; c++) begin
      @(negedge Clock);
      HS = (c < 2) ? SYNC : !SYNC;
      VS = vs_on ? SYNC : !SYNC;
      DE = (c >= 4) && (c < 4 + de_w);
      R  = DE ? pix : 8'd0;
      G  = R;
      B  = R;
    end
  endtask

  // Lines first_ln..last_ln of an 8-line frame; VS on lines 0-1, DE on 2-5.
  task automatic send_frame(input int first_ln, input int last_ln,
                            input int short_ln, input int w0, input int w1,
                            input int w2, input int w3, input logic [7:0] pix);
    int w;
    for (int ln = first_ln; ln <= last_ln; ln++) begin
      case (ln)
        2: w = w0;
        3: w = w1;
        4: w = w2;
        5: w = w3;
        default: w = 0;
      endcase
      send_line((ln == short_ln) ? 15 : 16, w, ln < 2, pix);
    end
  endtask

  task automatic clean_frame(input logic [7:0] pix);
    send_frame(0, 7, -1, 8, 8, 8, 8, pix);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    n_checks++; if ({LineTotal, LineWidth, FrameActive, FrameTotal} !== 48'd0) $display("FAIL reset_meas: got %h expected 0", {LineTotal, LineWidth, FrameActive, FrameTotal}); else n_pass++;
    n_checks++; if ({FrameSum, FrameCount, ErrFlags, FrameDone, Locked} !== 38'd0) $display("FAIL reset_status: got %h expected 0", {FrameSum, FrameCount, ErrFlags, FrameDone, Locked}); else n_pass++;
    Reset = 1'b0;
    clear_log();
    idle(6);
    n_checks++; if (FrameCount !== 16'd0 || Locked !== 1'b0) $display("FAIL reset_idle: count %0d locked %b expected 0 0", FrameCount, Locked); else n_pass++;
  endtask

  task automatic test_clean();
    apply_reset();
    repeat (3) clean_frame(8'h10);
    idle(4);
    n_checks++; if (q_err.size() !== 2) $display("FAIL clean_done_count: got %0d expected 2", q_err.size()); else n_pass++;
    if (q_err.size() == 2) begin
      n_checks++; if (q_lt[1] !== 12'd16) $display("FAIL clean_line_total: got %0d expected 16", q_lt[1]); else n_pass++;
      n_checks++; if (q_lw[1] !== 12'd8) $display("FAIL clean_line_width: got %0d expected 8", q_lw[1]); else n_pass++;
      n_checks++; if (q_act[1] !== 12'd4) $display("FAIL clean_active: got %0d expected 4", q_act[1]); else n_pass++;
      n_checks++; if (q_tot[1] !== 12'd8) $display("FAIL clean_total: got %0d expected 8", q_tot[1]); else n_pass++;
      n_checks++; if (q_err[0] !== 4'd0 || q_err[1] !== 4'd0) $display("FAIL clean_err: got %b %b expected 0000 0000", q_err[0], q_err[1]); else n_pass++;
      n_checks++; if (q_lock[0] !== 1'b0 || q_lock[1] !== 1'b1) $display("FAIL clean_lock: got %b %b expected 0 1", q_lock[0], q_lock[1]); else n_pass++;
      n_checks++; if (q_cnt[0] !== 16'd1 || q_cnt[1] !== 16'd2) $display("FAIL clean_count: got %0d %0d expected 1 2", q_cnt[0], q_cnt[1]); else n_pass++;
      n_checks++; if (q_sum[1] !== 16'd1536) $display("FAIL clean_sum: got %0d expected 1536", q_sum[1]); else n_pass++;
    end
    n_checks++; if (FrameCount !== 16'd2 || Locked !== 1'b1) $display("FAIL clean_final: count %0d locked %b expected 2 1", FrameCount, Locked); else n_pass++;
  endtask

  task automatic test_checksum();
    apply_reset();
    clean_frame(8'h01);
    clean_frame(8'hFF);
    clean_frame(8'h00);
    n_checks++; if (q_sum.size() !== 2) $display("FAIL sum_done_count: got %0d expected 2", q_sum.size()); else n_pass++;
    if (q_sum.size() == 2) begin
      n_checks++; if (q_sum[0] !== 16'd96) $display("FAIL sum_ones: got %0d expected 96", q_sum[0]); else n_pass++;
      n_checks++; if (q_sum[1] !== 16'd24480) $display("FAIL sum_ff: got %0d expected 24480", q_sum[1]); else n_pass++;
    end
  endtask

  task automatic test_short_line();
    apply_reset();
    clean_frame(8'h05);
    clean_frame(8'h05);
    send_frame(0, 7, 3, 8, 8, 8, 8, 8'h05);
    clean_frame(8'h05);
    clean_frame(8'h05);
    clean_frame(8'h05);
    n_checks++; if (q_err.size() !== 5) $display("FAIL short_done_count: got %0d expected 5", q_err.size()); else n_pass++;
    if (q_err.size() == 5) begin
      n_checks++; if (q_lock[1] !== 1'b1) $display("FAIL short_lock_before: got %b expected 1", q_lock[1]); else n_pass++;
      n_checks++; if (q_err[2] !== 4'b0001) $display("FAIL short_err: got %b expected 0001", q_err[2]); else n_pass++;
      n_checks++; if (q_lock[2] !== 1'b0) $display("FAIL short_lock_drop: got %b expected 0", q_lock[2]); else n_pass++;
      n_checks++; if (q_lock[3] !== 1'b0 || q_lock[4] !== 1'b1) $display("FAIL short_relock: got %b %b expected 0 1", q_lock[3], q_lock[4]); else n_pass++;
      n_checks++; if (q_err[3] !== 4'd0 || q_err[4] !== 4'd0) $display("FAIL short_err_after: got %b %b expected 0000 0000", q_err[3], q_err[4]); else n_pass++;
    end
  endtask

  task automatic test_de_errors();
    apply_reset();
    send_frame(0, 7, -1, 8, 7, 8, 0, 8'h03);
    clean_frame(8'h03);
    n_checks++; if (q_err.size() !== 1) $display("FAIL de_done_count: got %0d expected 1", q_err.size()); else n_pass++;
    if (q_err.size() == 1) begin
      n_checks++; if (q_err[0] !== 4'b0110) $display("FAIL de_err: got %b expected 0110", q_err[0]); else n_pass++;
      n_checks++; if (q_lw[0] !== 12'd8) $display("FAIL de_width: got %0d expected 8", q_lw[0]); else n_pass++;
      n_checks++; if (q_act[0] !== 12'd3) $display("FAIL de_active: got %0d expected 3", q_act[0]); else n_pass++;
      n_checks++; if (q_lock[0] !== 1'b0) $display("FAIL de_lock: got %b expected 0", q_lock[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    repeat (3) clean_frame(8'h02);
    n_checks++; if (Locked !== 1'b1 || FrameCount !== 16'd2) $display("FAIL mid_pre: locked %b count %0d expected 1 2", Locked, FrameCount); else n_pass++;
    send_frame(0, 3, -1, 8, 8, 8, 8, 8'h02);
    @(negedge Clock);
    Reset = 1'b1; HS = !SYNC; VS = !SYNC; DE = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    n_checks++; if ({LineTotal, LineWidth, FrameActive, FrameTotal} !== 48'd0) $display("FAIL mid_reset_meas: got %h expected 0", {LineTotal, LineWidth, FrameActive, FrameTotal}); else n_pass++;
    n_checks++; if ({FrameSum, FrameCount, ErrFlags, FrameDone, Locked} !== 38'd0) $display("FAIL mid_reset_status: got %h expected 0", {FrameSum, FrameCount, ErrFlags, FrameDone, Locked}); else n_pass++;
    @(negedge Clock);
    Reset = 1'b0;
    clear_log();
    send_frame(4, 7, -1, 8, 8, 8, 8, 8'h02);
    clean_frame(8'h02);
    n_checks++; if (q_err.size() !== 0) $display("FAIL mid_first_edge: got %0d reports expected 0", q_err.size()); else n_pass++;
    clean_frame(8'h02);
    n_checks++; if (q_err.size() !== 1) $display("FAIL mid_second_edge: got %0d reports expected 1", q_err.size()); else n_pass++;
    if (q_err.size() == 1) begin
      n_checks++; if (q_err[0] !== 4'd0 || q_cnt[0] !== 16'd1) $display("FAIL mid_report: err %b count %0d expected 0000 1", q_err[0], q_cnt[0]); else n_pass++;
      n_checks++; if (q_tot[0] !== 12'd8 || q_act[0] !== 12'd4 || q_lt[0] !== 12'd16) $display("FAIL mid_values: total %0d active %0d line %0d expected 8 4 16", q_tot[0], q_act[0], q_lt[0]); else n_pass++;
      n_checks++; if (q_sum[0] !== 16'd192) $display("FAIL mid_sum: got %0d expected 192", q_sum[0]); else n_pass++;
    end
  endtask

  task automatic test_de_saturate();
    apply_reset();
    idle(4);
    for (int i = 0; i < 2; i++) begin @(negedge Clock); VS = SYNC; end
    idle(4);
    for (int i = 0; i < 5000; i++) begin @(negedge Clock); DE = 1'b1; end
    idle(4);
    n_checks++; if (LineWidth !== 12'd4095) $display("FAIL sat_width: got %0d expected 4095", LineWidth); else n_pass++;
    for (int i = 0; i < 2; i++) begin @(negedge Clock); VS = SYNC; end
    idle(6);
    n_checks++; if (q_err.size() !== 1) $display("FAIL sat_done_count: got %0d expected 1", q_err.size()); else n_pass++;
    if (q_err.size() == 1) begin
      n_checks++; if (q_err[0] !== 4'b1110) $display("FAIL sat_err: got %b expected 1110", q_err[0]); else n_pass++;
      n_checks++; if (q_act[0] !== 12'd1 || q_tot[0] !== 12'd0) $display("FAIL sat_counts: active %0d total %0d expected 1 0", q_act[0], q_tot[0]); else n_pass++;
      n_checks++; if (q_lw[0] !== 12'd4095 || q_lt[0] !== 12'd0) $display("FAIL sat_line: width %0d total %0d expected 4095 0", q_lw[0], q_lt[0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_checksum();
    test_short_line();
    test_de_errors();
    test_reset_mid_frame();
    test_de_saturate();
    n_checks++; if (dbl_cnt !== 0) $display("FAIL done_pulse_width: got %0d long pulses expected 0", dbl_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
